dout_mem_reader: RTL and testbench
==================================

# dout_mem_reader

Read-side drain engine for the processor's output data memory. After the vector processor finishes writing results, this block walks the memory sequentially from base address 24 and unpacks each 24-bit word into 8-bit pixels. It streams the pixels MSB-byte-first over a valid/ready interface to the I/O side, for example a host link or frame sink. It owns the memory's read port only; the processor keeps the write port.

## Interface
- WIDTH, 24, memory word width; must be an integer multiple of PIXEL
- DEPTH, 10000, number of words in output memory
- PIXEL, 8, pixel width; PPW = WIDTH/PIXEL pixels per word (3 by default)
- BASE, 24, processor-visible address of word 0
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a drain; sampled only in IDLE
- len  in  $clog2(DEPTH+1)  words to drain; latched on accepted start; 0 or >DEPTH means DEPTH
- mem_re  out  1  read strobe to output memory
- mem_addr  out  WIDTH  read address = BASE + word index
- mem_rd  in  WIDTH  read data, valid exactly one cycle after mem_re
- px_data  out  PIXEL  current pixel
- px_valid  out  1  px_data valid
- px_ready  in  1  sink accepts when px_valid && px_ready
- px_last  out  1  high with the final pixel of the drain
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse in DONE
- checksum  out  16  running pixel sum (see Configuration)

## Operation
- FSM states: IDLE, FETCH, WAIT, SHIFT, DONE.
- IDLE: when start=1, latch len (clamped), clear word index and pixel counter, and go to FETCH. start in any other state is ignored.
- FETCH: mem_re=1, mem_addr=BASE+idx; next state is WAIT.
- WAIT: capture mem_rd into the shift register, set pixel counter to 0, and go to SHIFT.
- SHIFT: px_valid=1; px_data = shift_reg[WIDTH-1 -: PIXEL] (MSB byte first). On each handshake, shift left by PIXEL and increment the pixel counter. The last pixel of a word is the one at counter = PPW-1.
  - If idx+1 < len at that handshake: idx++ and go to FETCH.
  - Otherwise go to DONE.
- px_last = px_valid && (idx == len-1) && (pixel counter == PPW-1).
- DONE: done=1 for one cycle, then IDLE.
- px_data/px_last are held stable while px_valid && !px_ready.
- Word index arithmetic is unsigned. mem_addr is zero-extended idx + BASE at WIDTH bits and never exceeds BASE+DEPTH-1.

## Timing
- Reset values: mem_re=0, mem_addr=BASE, px_valid=0, px_data=0, px_last=0, busy=0, done=0, checksum=0, state=IDLE.
- start at cycle T:
  - busy=1 from T+1.
  - First mem_re at T+1.
  - First px_valid at T+3.
- Per word with px_ready held high: 2 fetch cycles plus PPW shift cycles, i.e. 5 cycles for 3 pixels.
- Final handshake at cycle N: done=1 at N+1; busy=0 and state=IDLE at N+2.
- rst asserted mid-drain: outputs go to their reset values immediately and asynchronously. The partial drain is discarded; there is no resume.
- len=1 drains exactly PPW pixels; px_last is set on pixel PPW-1.

## Configuration
- DOUT_READER_CHECKSUM_EN defined:
  - checksum clears on accepted start.
  - It adds zero-extended px_data on every handshake, modulo 2^16.
  - It holds its value after DONE until the next start.
- Not defined: checksum is tied to 0 and no adder or register is synthesized.

## Structure
- Package dout_pkg holds:
  - DOUT_BASE=24, DOUT_DEPTH=10000, WORD_W=24, PIX_W=8
  - derived PPW
  - the FSM state enum typedef
- Sub-module dout_word_unpacker holds the shift register, pixel counter, and the valid/ready hold logic. It signals word_done to the parent FSM.

## Test plan
- Preload words 0x112233 and 0x445566, len=2, px_ready=1 -> pixels 11,22,33,44,55,66; px_last on 66; mem_addr 24 then 25; done 1 cycle after the 66 handshake.
- len=0 -> exactly 10000 mem_re pulses; last mem_addr=10023; 30000 pixels.
- Same preload, px_ready toggled 1,0,0,1 pseudo-randomly -> identical pixel sequence, px_data stable while stalled, no drops or duplicates.
- rst asserted after the 4th pixel of a len=5 drain -> px_valid=0 and busy=0 immediately; a new start at len=1 yields 3 pixels from address 24.
- start pulsed while busy -> ignored; drain length and addresses unchanged.
- With DOUT_READER_CHECKSUM_EN, words 0xFFFFFF x 100 -> checksum = (300*255) mod 65536 = 0x2AD4. Without the macro -> checksum stays 0.

Source files
------------

// File: rtl/dout_pkg.sv
// Shared constants and FSM state encoding for the output-memory drain engine.
package dout_pkg;
    localparam int DOUT_BASE  = 24;
    localparam int DOUT_DEPTH = 10000;
    localparam int WORD_W     = 24;
    localparam int PIX_W      = 8;
    localparam int PPW        = WORD_W / PIX_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/dout_word_unpacker.sv
// Holds one memory word and presents it MSB pixel first; shifts only on handshake,
// so px_data is frozen while the sink stalls. word_done marks the last pixel's handshake.
module dout_word_unpacker
    import dout_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int PIXEL = PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             active,
    input  logic [WIDTH-1:0] word_in,
    input  logic             px_ready,
    output logic [PIXEL-1:0] px_data,
    output logic             px_valid,
    output logic             last_px,
    output logic             word_done
);
    localparam int N  = WIDTH / PIXEL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt       <= '0;
        end else if (load) begin
            shift_reg <= word_in;
            cnt       <= '0;
        end else if (clear) begin
            cnt       <= '0;
        end else if (px_valid && px_ready) begin
            shift_reg <= shift_reg << PIXEL;
            cnt       <= cnt + CW'(1);
        end
    end

    assign px_valid  = active;
    assign px_data   = shift_reg[WIDTH-1 -: PIXEL];
    assign last_px   = (cnt == CW'(N - 1));
    assign word_done = px_valid && px_ready && last_px;
endmodule

// File: rtl/dout_mem_reader.sv
// Drains output memory from BASE, streaming MSB-first pixels over valid/ready; 5 cycles/word unstalled.
// Optional running pixel checksum when DOUT_READER_CHECKSUM_EN is defined, otherwise tied to 0.
module dout_mem_reader
    import dout_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = DOUT_DEPTH,
    parameter int PIXEL = PIX_W,
    parameter int BASE  = DOUT_BASE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(DEPTH+1)-1:0] len,
    output logic                       mem_re,
    output logic [WIDTH-1:0]           mem_addr,
    input  logic [WIDTH-1:0]           mem_rd,
    output logic [PIXEL-1:0]           px_data,
    output logic                       px_valid,
    input  logic                       px_ready,
    output logic                       px_last,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                checksum
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    state_t           state;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_clamped;
    logic             accept;
    logic             more;
    logic             last_px;
    logic             word_done;

    assign accept      = (state == S_IDLE) && start;
    assign len_clamped = (len == '0 || len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    assign more        = ({1'b0, idx} + (LEN_W+1)'(1)) < {1'b0, len_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    len_q <= len_clamped;
                    idx   <= '0;
                    state <= S_FETCH;
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT:  state <= S_SHIFT;
                S_SHIFT: if (word_done) begin
                    if (more) begin
                        idx   <= idx + LEN_W'(1);
                        state <= S_FETCH;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    dout_word_unpacker #(
        .WIDTH(WIDTH),
        .PIXEL(PIXEL)
    ) u_unpack (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .load     (state == S_WAIT),
        .active   (state == S_SHIFT),
        .word_in  (mem_rd),
        .px_ready (px_ready),
        .px_data  (px_data),
        .px_valid (px_valid),
        .last_px  (last_px),
        .word_done(word_done)
    );

    assign mem_re   = (state == S_FETCH);
    assign mem_addr = WIDTH'(idx) + WIDTH'(BASE);
    assign px_last  = px_valid && (idx == len_q - LEN_W'(1)) && last_px;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

`ifdef DOUT_READER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (px_valid && px_ready) begin
            sum_q <= sum_q + 16'(px_data);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_dout_mem_reader.sv
// Directed bench for dout_mem_reader with a one-cycle-latency memory model and a handshake monitor.
module tb_dout_mem_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] len = '0;
    logic        mem_re;
    logic [23:0] mem_addr;
    logic [23:0] mem_rd = '0;
    logic [7:0]  px_data;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic        px_last;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    dout_mem_reader dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_last(px_last), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [10000];
    always @(posedge clk) if (mem_re) mem_rd <= mem[mem_addr - 24'd24];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness: held high, or the repeating 1,0,0,1 stall pattern.
    bit rdy_mode = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pk = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            px_ready = pat[pk];
            pk = (pk + 1) % 4;
        end else begin
            px_ready = 1'b1;
        end
    end

    logic [7:0]  px_q [$];
    bit          last_q [$];
    logic [23:0] addr_q [$];
    int nre, ndone, first_re, first_vld, stall_err, hs_cyc, done_cyc;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_re) begin
                nre++;
                addr_q.push_back(mem_addr);
                if (first_re < 0) first_re = cyc;
            end
            if (px_valid && first_vld < 0) first_vld = cyc;
            if (prev_stall && (!px_valid || px_data !== prev_data || px_last !== prev_last)) stall_err++;
            if (px_valid && px_ready) begin
                px_q.push_back(px_data);
                last_q.push_back(px_last);
                hs_cyc = cyc;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            prev_stall = px_valid && !px_ready;
            prev_data  = px_data;
            prev_last  = px_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void clear_mon();
        px_q.delete(); last_q.delete(); addr_q.delete();
        nre = 0; ndone = 0; first_re = -1; first_vld = -1; stall_err = 0;
        hs_cyc = -1; done_cyc = -1;
    endfunction

    int start_cyc;
    task automatic start_drain(input logic [13:0] l);
        len = l;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (ndone == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (ndone == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mem_re, px_valid, px_last, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got re/vld/last/busy/done=%b expected 00000",
                     {mem_re, px_valid, px_last, busy, done});
        end
        checks++;
        if (mem_addr !== 24'd24) begin
            errors++; $display("FAIL reset_addr: got %0d expected 24", mem_addr);
        end
        checks++;
        if (px_data !== 8'h00 || checksum !== 16'h0) begin
            errors++; $display("FAIL reset_data: got px=%h sum=%h expected 00/0000", px_data, checksum);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp [6];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        mem[0] = 24'h112233; mem[1] = 24'h445566;
        rdy_mode = 1'b0;
        clear_mon();
        start_drain(14'd2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_t1: got %b expected 1", busy); end
        wait_done(100, "basic");
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
        checks++;
        if (first_re !== start_cyc + 1 || first_vld !== start_cyc + 3) begin
            errors++;
            $display("FAIL basic_latency: got re@+%0d vld@+%0d expected +1/+3",
                     first_re - start_cyc, first_vld - start_cyc);
        end
        checks++;
        if (px_q.size() != 6) begin
            errors++; $display("FAIL basic_count: got %0d expected 6", px_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (px_q[i] !== exp[i] || last_q[i] !== (i == 5)) begin
                    errors++;
                    $display("FAIL basic_px%0d: got %h last=%b expected %h last=%b",
                             i, px_q[i], last_q[i], exp[i], (i == 5));
                end
            end
        end
        checks++;
        if (addr_q.size() != 2 || addr_q[0] !== 24'd24 || addr_q[1] !== 24'd25) begin
            errors++; $display("FAIL basic_addr: got %0d reads expected 24,25", addr_q.size());
        end
        checks++;
        if (done_cyc !== hs_cyc + 1 || ndone != 1) begin
            errors++;
            $display("FAIL basic_done: got done@%0d (n=%0d) expected @%0d once", done_cyc, ndone, hs_cyc + 1);
        end
    endtask

    task automatic test_len0();
        int nlast = 0;
        for (int i = 0; i < 10000; i++) mem[i] = 24'(i);
        clear_mon();
        start_drain(14'd0);
        wait_done(52000, "len0");
        foreach (last_q[i]) if (last_q[i]) nlast++;
        checks++;
        if (nre != 10000) begin errors++; $display("FAIL len0_reads: got %0d expected 10000", nre); end
        checks++;
        if (addr_q.size() == 0 || addr_q[addr_q.size()-1] !== 24'd10023) begin
            errors++; $display("FAIL len0_last_addr: got %0d expected 10023",
                               addr_q.size() ? addr_q[addr_q.size()-1] : 24'd0);
        end
        checks++;
        if (px_q.size() != 30000 || nlast != 1) begin
            errors++; $display("FAIL len0_pixels: got %0d px, %0d last expected 30000, 1", px_q.size(), nlast);
        end
        checks++;
        if (px_q.size() == 0 || px_q[px_q.size()-1] !== 8'h0F || !last_q[last_q.size()-1]) begin
            errors++; $display("FAIL len0_final_px: got %h expected 0f with last", px_q.size() ? px_q[px_q.size()-1] : 8'h0);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [7:0] exp [6];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        mem[0] = 24'h112233; mem[1] = 24'h445566;
        rdy_mode = 1'b1;
        clear_mon();
        start_drain(14'd2);
        wait_done(200, "stall");
        rdy_mode = 1'b0;
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL stall_hold: got %0d changes expected 0", stall_err); end
        checks++;
        if (px_q.size() != 6) begin
            errors++; $display("FAIL stall_count: got %0d expected 6", px_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (px_q[i] !== exp[i] || last_q[i] !== (i == 5)) begin
                    errors++;
                    $display("FAIL stall_px%0d: got %h last=%b expected %h last=%b",
                             i, px_q[i], last_q[i], exp[i], (i == 5));
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mem[0] = 24'h112233; mem[1] = 24'h445566; mem[2] = 24'h778899;
        mem[3] = 24'hAABBCC; mem[4] = 24'hDDEEFF;
        clear_mon();
        start_drain(14'd5);
        while (px_q.size() < 4 && n < 100) begin tick(); n++; end
        checks++;
        if (px_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got vld=%b busy=%b expected 1/1", px_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (px_valid !== 1'b0 || busy !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 24'd24) begin
            errors++;
            $display("FAIL rstmid_async: got vld=%b busy=%b re=%b addr=%0d expected 0/0/0/24",
                     px_valid, busy, mem_re, mem_addr);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_mon();
        start_drain(14'd1);
        wait_done(100, "rstmid");
        checks++;
        if (px_q.size() != 3 || addr_q.size() != 1 || addr_q[0] !== 24'd24) begin
            errors++; $display("FAIL rstmid_restart: got %0d px %0d reads expected 3 px from 24",
                               px_q.size(), addr_q.size());
        end else begin
            checks++;
            if (px_q[0] !== 8'h11 || px_q[1] !== 8'h22 || px_q[2] !== 8'h33 || last_q[2] !== 1'b1 || last_q[1] !== 1'b0) begin
                errors++; $display("FAIL rstmid_px: got %h %h %h last=%b expected 11 22 33 last on 33",
                                   px_q[0], px_q[1], px_q[2], last_q[2]);
            end
        end
        tick();
    endtask

    task automatic test_start_busy();
        mem[0] = 24'h112233; mem[1] = 24'h445566;
        clear_mon();
        start_drain(14'd2);
        tick(); tick();
        len = 14'd5; start = 1'b1; tick(); start = 1'b0;
        wait_done(100, "busy_start");
        tick(); tick();
        checks++;
        if (nre != 2 || px_q.size() != 6 || ndone != 1) begin
            errors++; $display("FAIL busy_start_len: got %0d reads %0d px %0d done expected 2/6/1",
                               nre, px_q.size(), ndone);
        end
        checks++;
        if (addr_q.size() != 2 || addr_q[0] !== 24'd24 || addr_q[1] !== 24'd25) begin
            errors++; $display("FAIL busy_start_addr: got %0d reads expected 24,25", addr_q.size());
        end
    endtask

    task automatic test_checksum();
        logic [15:0] exp_sum;
`ifdef DOUT_READER_CHECKSUM_EN
        exp_sum = 16'h2AD4;
`else
        exp_sum = 16'h0000;
`endif
        for (int i = 0; i < 100; i++) mem[i] = 24'hFFFFFF;
        clear_mon();
        start_drain(14'd100);
        wait_done(1000, "checksum");
        checks++;
        if (checksum !== exp_sum) begin
            errors++; $display("FAIL checksum_value: got %h expected %h", checksum, exp_sum);
        end
        repeat (3) tick();
        checks++;
        if (checksum !== exp_sum) begin
            errors++; $display("FAIL checksum_hold: got %h expected %h", checksum, exp_sum);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_len0();
        test_stall();
        test_reset_mid();
        test_start_busy();
        test_checksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
